// File: rtl/write_back_arbiter_pkg.sv
// Shared types for the register-file write-back arbiter.
// Covers the write-back type codes and the MDU skid-buffer FSM states.
package write_back_arbiter_pkg;

  typedef enum logic [1:0] {
    WB_NORMAL = 2'd0,
    WB_LOAD   = 2'd1,
    WB_JAL    = 2'd2,
    WB_HICCUP = 2'd3
  } wb_type_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HELD  = 2'd1,
    ST_FORCE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/write_back_arbiter_skid_buffer.sv
// One-entry holding register for a completed MDU result (rd + value).
// Accepts a result only when empty, and empties when the arbiter pops it.
module wb_skid_buffer
  import write_back_arbiter_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [XLEN-1:0]   in_value,
  input  logic              pop,
  output logic [REG_AW-1:0] out_rd,
  output logic [XLEN-1:0]   out_value
);

  logic              valid_q, valid_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic [XLEN-1:0]   value_q, value_d;

  // Load when empty; loading and popping are mutually exclusive because pop needs a full entry.
  always_comb begin
    in_ready = ~valid_q;
    valid_d  = valid_q;
    rd_d     = rd_q;
    value_d  = value_q;
    if (in_valid && !valid_q) begin
      valid_d = 1'b1;
      rd_d    = in_rd;
      value_d = in_value;
    end else if (pop) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      rd_q    <= {REG_AW{1'b0}};
      value_q <= {XLEN{1'b0}};
    end else begin
      valid_q <= valid_d;
      rd_q    <= rd_d;
      value_q <= value_d;
    end
  end

  assign out_rd    = rd_q;
  assign out_value = value_q;

endmodule

// File: rtl/write_back_arbiter.sv
// Owns the single register-file write port: pipeline write-back has priority, a buffered
// MDU result is granted when the pipe is idle or after MAX_WAIT lost arbitrations.
module write_back_arbiter
  import write_back_arbiter_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int REG_AW   = 5,
  parameter int MAX_WAIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pipe_valid,
  input  logic [REG_AW-1:0]     pipe_rd,
  input  logic [XLEN-1:0]       pipe_value,
  output logic                  pipe_stall,
  input  logic                  issue_valid,
  input  logic [REG_AW-1:0]     issue_rd,
  input  logic                  mdu_valid,
  input  logic [REG_AW-1:0]     mdu_rd,
  input  logic [XLEN-1:0]       mdu_value,
  output logic                  mdu_ready,
  output logic                  rf_we,
  output logic [REG_AW-1:0]     rf_waddr,
  output logic [XLEN-1:0]       rf_wdata,
  output logic [2**REG_AW-1:0]  busy_mask
);

  localparam int              NREG    = 2**REG_AW;
  localparam int              CW      = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0]   MAX_CNT = CW'(MAX_WAIT);

  arb_state_e        state_q, state_d;
  logic [CW-1:0]     wait_cnt_q, wait_cnt_d, wait_inc;
  logic              rf_we_q, rf_we_d;
  logic [REG_AW-1:0] rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0]   rf_wdata_q, rf_wdata_d;
  logic [NREG-1:0]   busy_q, busy_d;

  logic              buf_load, buf_pop;
  logic [REG_AW-1:0] buf_rd;
  logic [XLEN-1:0]   buf_value;
  logic              pipe_grant, mdu_grant, waw_drop;

  wb_skid_buffer #(.XLEN(XLEN), .REG_AW(REG_AW)) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (buf_load),
    .in_ready (mdu_ready),
    .in_rd    (mdu_rd),
    .in_value (mdu_value),
    .pop      (buf_pop),
    .out_rd   (buf_rd),
    .out_value(buf_value)
  );

  assign buf_load = mdu_valid & mdu_ready;
  assign buf_pop  = mdu_grant | waw_drop;
  assign wait_inc = (wait_cnt_q == MAX_CNT) ? wait_cnt_q : wait_cnt_q + CW'(1);

  // Arbitration FSM; a pipe write to the buffered rd makes the buffered result stale.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    pipe_grant = 1'b0;
    mdu_grant  = 1'b0;
    waw_drop   = 1'b0;
    pipe_stall = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        pipe_grant = pipe_valid;
        wait_cnt_d = {CW{1'b0}};
        state_d    = buf_load ? ST_HELD : ST_EMPTY;
      end
      ST_HELD: begin
        if (pipe_valid) begin
          pipe_grant = 1'b1;
          if (pipe_rd == buf_rd) begin
            waw_drop   = 1'b1;
            state_d    = ST_EMPTY;
            wait_cnt_d = {CW{1'b0}};
          end else begin
            wait_cnt_d = wait_inc;
            state_d    = (wait_inc == MAX_CNT) ? ST_FORCE : ST_HELD;
          end
        end else begin
          mdu_grant  = 1'b1;
          state_d    = ST_EMPTY;
          wait_cnt_d = {CW{1'b0}};
        end
      end
      ST_FORCE: begin
        if (pipe_valid && (pipe_rd == buf_rd)) begin
          pipe_grant = 1'b1;
          waw_drop   = 1'b1;
        end else begin
          mdu_grant  = 1'b1;
          pipe_stall = pipe_valid;
        end
        state_d    = ST_EMPTY;
        wait_cnt_d = {CW{1'b0}};
      end
      default: begin
        state_d    = ST_EMPTY;
        wait_cnt_d = {CW{1'b0}};
      end
    endcase
  end

  // RF port and busy mask next values; rd 0 never writes and never marks busy.
  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (pipe_grant && (pipe_rd != {REG_AW{1'b0}})) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = pipe_rd;
      rf_wdata_d = pipe_value;
    end else if (mdu_grant && (buf_rd != {REG_AW{1'b0}})) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = buf_rd;
      rf_wdata_d = buf_value;
    end else begin
      rf_we_d = 1'b0;
    end

    busy_d = busy_q;
    if (buf_pop) begin
      busy_d[buf_rd] = 1'b0;
    end else begin
      busy_d = busy_q;
    end
    if (issue_valid && (issue_rd != {REG_AW{1'b0}})) begin
      busy_d[issue_rd] = 1'b1;
    end else begin
      busy_d[0] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      wait_cnt_q <= {CW{1'b0}};
      rf_we_q    <= 1'b0;
      rf_waddr_q <= {REG_AW{1'b0}};
      rf_wdata_q <= {XLEN{1'b0}};
      busy_q     <= {NREG{1'b0}};
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      busy_q     <= busy_d;
    end
  end

  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign busy_mask = busy_q;

endmodule

// File: tb/tb_write_back_arbiter.sv
// Scoreboard bench for write_back_arbiter: expected RF writes are queued as stimulus is
// driven and popped by a monitor whenever the DUT asserts rf_we.
module tb_write_back_arbiter;

  localparam int XLEN     = 32;
  localparam int REG_AW   = 5;
  localparam int MAX_WAIT = 4;

  logic              clk;
  logic              rst_n;
  logic              pipe_valid;
  logic [REG_AW-1:0] pipe_rd;
  logic [XLEN-1:0]   pipe_value;
  logic              pipe_stall;
  logic              issue_valid;
  logic [REG_AW-1:0] issue_rd;
  logic              mdu_valid;
  logic [REG_AW-1:0] mdu_rd;
  logic [XLEN-1:0]   mdu_value;
  logic              mdu_ready;
  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [XLEN-1:0]   rf_wdata;
  logic [31:0]       busy_mask;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   val;
  } wr_t;

  wr_t sb[$];
  wr_t mon_exp;
  int  n_checks = 0;
  int  n_pass   = 0;

  write_back_arbiter #(.XLEN(XLEN), .REG_AW(REG_AW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pipe_valid (pipe_valid),
    .pipe_rd    (pipe_rd),
    .pipe_value (pipe_value),
    .pipe_stall (pipe_stall),
    .issue_valid(issue_valid),
    .issue_rd   (issue_rd),
    .mdu_valid  (mdu_valid),
    .mdu_rd     (mdu_rd),
    .mdu_value  (mdu_value),
    .mdu_ready  (mdu_ready),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .busy_mask  (busy_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every RF write must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rf_we === 1'b1) begin
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL rf_write_unexpected: got waddr=%0d wdata=0x%0h, expected no write", rf_waddr, rf_wdata);
      end else begin
        mon_exp = sb.pop_front();
        if ({rf_waddr, rf_wdata} !== mon_exp) begin
          $display("FAIL rf_write: got waddr=%0d wdata=0x%0h, expected waddr=%0d wdata=0x%0h",
                   rf_waddr, rf_wdata, mon_exp.rd, mon_exp.val);
        end else begin
          n_pass++;
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    pipe_valid  = 1'b0;
    pipe_rd     = 5'd0;
    pipe_value  = 32'd0;
    issue_valid = 1'b0;
    issue_rd    = 5'd0;
    mdu_valid   = 1'b0;
    mdu_rd      = 5'd0;
    mdu_value   = 32'd0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    n_checks++;
    if ({rf_we, rf_waddr, rf_wdata, busy_mask} !== 70'd0) begin
      $display("FAIL reset_regs: got we=%b addr=%0d data=0x%0h busy=0x%0h, expected all 0",
               rf_we, rf_waddr, rf_wdata, busy_mask);
    end else n_pass++;
    #1;
    n_checks++;
    if ({mdu_ready, pipe_stall} !== 2'b10) begin
      $display("FAIL reset_comb: got ready=%b stall=%b, expected ready=1 stall=0", mdu_ready, pipe_stall);
    end else n_pass++;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_pipe_only();
    wr_t w;
    pipe_valid = 1'b1;
    pipe_rd    = 5'd5;
    pipe_value = 32'h11;
    sb.push_back({5'd5, 32'h11});
    #1;
    n_checks++;
    if (pipe_stall !== 1'b0) $display("FAIL pipe_stall_idle: got %b, expected 0", pipe_stall);
    else n_pass++;
    step();
    for (int i = 0; i < 3; i++) begin
      w.rd  = 5'(1 + $urandom_range(30));
      w.val = $urandom;
      pipe_rd    = w.rd;
      pipe_value = w.val;
      sb.push_back(w);
      step();
    end
    idle_inputs();
    step();
    step();
    n_checks++;
    if (sb.size() != 0) $display("FAIL pipe_drain: got %0d pending writes, expected 0", sb.size());
    else n_pass++;
  endtask

  task automatic test_mdu_idle_pipe();
    issue_valid = 1'b1;
    issue_rd    = 5'd7;
    step();
    issue_valid = 1'b0;
    n_checks++;
    if (busy_mask[7] !== 1'b1) $display("FAIL busy_set: got busy[7]=%b, expected 1", busy_mask[7]);
    else n_pass++;
    mdu_valid = 1'b1;
    mdu_rd    = 5'd7;
    mdu_value = 32'hAB;
    sb.push_back({5'd7, 32'hAB});
    step();
    idle_inputs();
    #1;
    n_checks++;
    if (mdu_ready !== 1'b0) $display("FAIL mdu_ready_held: got %b, expected 0", mdu_ready);
    else n_pass++;
    step();
    n_checks++;
    if (rf_we !== 1'b1 || busy_mask[7] !== 1'b0)
      $display("FAIL mdu_grant_latency: got we=%b busy[7]=%b, expected we=1 busy[7]=0", rf_we, busy_mask[7]);
    else n_pass++;
    #1;
    n_checks++;
    if (mdu_ready !== 1'b1) $display("FAIL mdu_ready_drained: got %b, expected 1", mdu_ready);
    else n_pass++;
    step();
  endtask

  task automatic test_starvation();
    logic exp_stall;
    logic exp_ready;
    mdu_valid = 1'b1;
    mdu_rd    = 5'd3;
    mdu_value = 32'h33;
    step();
    idle_inputs();
    for (int i = 0; i < 6; i++) begin
      pipe_valid = 1'b1;
      pipe_rd    = (i < 4) ? 5'(10 + i) : 5'd14;
      pipe_value = (i < 4) ? 32'(32'h100 + i) : 32'h104;
      exp_stall  = (i == 4) ? 1'b1 : 1'b0;
      exp_ready  = (i == 5) ? 1'b1 : 1'b0;
      if (i < 4) sb.push_back({pipe_rd, pipe_value});
      else if (i == 4) sb.push_back({5'd3, 32'h33});
      else sb.push_back({5'd14, 32'h104});
      #1;
      n_checks++;
      if (pipe_stall !== exp_stall || mdu_ready !== exp_ready)
        $display("FAIL starve_cycle%0d: got stall=%b ready=%b, expected stall=%b ready=%b",
                 i, pipe_stall, mdu_ready, exp_stall, exp_ready);
      else n_pass++;
      step();
    end
    idle_inputs();
    step();
    step();
    n_checks++;
    if (sb.size() != 0) $display("FAIL starve_drain: got %0d pending writes, expected 0", sb.size());
    else n_pass++;
  endtask

  task automatic test_waw();
    issue_valid = 1'b1;
    issue_rd    = 5'd9;
    step();
    idle_inputs();
    mdu_valid = 1'b1;
    mdu_rd    = 5'd9;
    mdu_value = 32'h99;
    step();
    idle_inputs();
    pipe_valid = 1'b1;
    pipe_rd    = 5'd9;
    pipe_value = 32'h55;
    sb.push_back({5'd9, 32'h55});
    #1;
    n_checks++;
    if (pipe_stall !== 1'b0) $display("FAIL waw_stall: got %b, expected 0", pipe_stall);
    else n_pass++;
    step();
    idle_inputs();
    #1;
    n_checks++;
    if (busy_mask[9] !== 1'b0 || mdu_ready !== 1'b1)
      $display("FAIL waw_drop: got busy[9]=%b ready=%b, expected busy[9]=0 ready=1", busy_mask[9], mdu_ready);
    else n_pass++;
    step();
    step();
    step();
    n_checks++;
    if (sb.size() != 0) $display("FAIL waw_drain: got %0d pending writes, expected 0", sb.size());
    else n_pass++;
  endtask

  task automatic test_rd_zero();
    pipe_valid  = 1'b1;
    pipe_rd     = 5'd0;
    pipe_value  = 32'h77;
    mdu_valid   = 1'b1;
    mdu_rd      = 5'd0;
    mdu_value   = 32'h88;
    issue_valid = 1'b1;
    issue_rd    = 5'd0;
    step();
    idle_inputs();
    #1;
    n_checks++;
    if (mdu_ready !== 1'b0) $display("FAIL rd0_held: got ready=%b, expected 0", mdu_ready);
    else n_pass++;
    step();
    #1;
    n_checks++;
    if (mdu_ready !== 1'b1 || busy_mask !== 32'd0)
      $display("FAIL rd0_drain: got ready=%b busy=0x%0h, expected ready=1 busy=0", mdu_ready, busy_mask);
    else n_pass++;
    step();
    step();
  endtask

  task automatic test_set_wins();
    issue_valid = 1'b1;
    issue_rd    = 5'd12;
    step();
    idle_inputs();
    mdu_valid = 1'b1;
    mdu_rd    = 5'd12;
    mdu_value = 32'hC0DE;
    sb.push_back({5'd12, 32'hC0DE});
    step();
    idle_inputs();
    issue_valid = 1'b1;
    issue_rd    = 5'd12;
    step();
    idle_inputs();
    n_checks++;
    if (busy_mask[12] !== 1'b1) $display("FAIL set_wins: got busy[12]=%b, expected 1", busy_mask[12]);
    else n_pass++;
    step();
  endtask

  task automatic test_reset_mid();
    issue_valid = 1'b1;
    issue_rd    = 5'd20;
    step();
    idle_inputs();
    mdu_valid = 1'b1;
    mdu_rd    = 5'd20;
    mdu_value = 32'h2020;
    step();
    idle_inputs();
    #1;
    n_checks++;
    if (busy_mask[20] !== 1'b1 || mdu_ready !== 1'b0)
      $display("FAIL pre_reset_held: got busy[20]=%b ready=%b, expected 1/0", busy_mask[20], mdu_ready);
    else n_pass++;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_checks++;
    if ({rf_we, rf_waddr, rf_wdata, busy_mask} !== 70'd0)
      $display("FAIL reset_mid_regs: got we=%b addr=%0d data=0x%0h busy=0x%0h, expected all 0",
               rf_we, rf_waddr, rf_wdata, busy_mask);
    else n_pass++;
    #1;
    n_checks++;
    if (mdu_ready !== 1'b1) $display("FAIL reset_mid_ready: got %b, expected 1", mdu_ready);
    else n_pass++;
    step();
    step();
    step();
    n_checks++;
    if (sb.size() != 0) $display("FAIL reset_mid_drain: got %0d pending writes, expected 0", sb.size());
    else n_pass++;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    step();
    test_reset();
    test_pipe_only();
    test_mdu_idle_pipe();
    test_starvation();
    test_waw();
    test_rd_zero();
    test_set_wins();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
